codec_init_sequencer: RTL and testbench
=======================================

Name: codec_init_sequencer

Overview:
Parametrised power-up register-initialisation sequencer for I2C-configured audio codecs (WM8731 default). Walks a table of NUM_REGS register words and issues one write per entry to an external I2C byte-write master through a req/done handshake. Adds the following behaviour:
- power-up delay
- inter-write gap
- NACK retry
- transfer timeout
- error reporting with failing index
- software re-run via START
Sits between the top-level audio wrapper and the I2C master.

Parameters:
NUM_REGS, 11, number of table entries (≥1).
WORD_W, 16, register word width: {reg addr[6:0], data[8:0]} for WM8731.
DEV_ADDR, 7'h1A, 7-bit I2C device address driven on XFER_DEV.
POWERUP_DLY, 256, cycles waited after reset before the first write (0 = none).
INTER_DLY, 64, idle cycles between consecutive write attempts (0 = none).
MAX_RETRY, 3, additional attempts per entry after a NACK/timeout.
TIMEOUT, 4096, cycles allowed in WAIT before an attempt counts as failed (0 = disabled).
AUTO_START, 1, 1 = run automatically after reset; 0 = wait for START.
IDX_W, $clog2(NUM_REGS) min 1, table index width.

Ports:
MCLK  in  1  system clock (50 MHz).
RESET  in  1  asynchronous, active-high reset.
START  in  1  single-cycle request to (re)run the sequence; honoured only when not BUSY.
TBL_IDX  out  IDX_W  registered index into the external combinational table.
TBL_DATA  in  WORD_W  table word for TBL_IDX, valid the cycle after TBL_IDX changes.
XFER_REQ  out  1  write request to the I2C master; level, held until XFER_DONE.
XFER_DEV  out  7  constant DEV_ADDR.
XFER_DATA  out  WORD_W  word to transmit, stable while XFER_REQ=1.
XFER_DONE  in  1  single-cycle completion pulse from the I2C master.
XFER_NACK  in  1  sampled only with XFER_DONE; 1 = slave NACKed.
BUSY  out  1  sequence in progress.
END  out  1  all entries written successfully; held until START or RESET.
ERROR  out  1  entry failed after MAX_RETRY retries; held until START or RESET.
ERR_IDX  out  IDX_W  index of the failed entry; valid while ERROR=1.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All outputs 0: XFER_REQ, BUSY, END, ERROR, ERR_IDX, TBL_IDX, XFER_DATA. Internal counters 0. XFER_REQ drops immediately even mid-transfer; no completion is awaited.
- All outputs are registered.
- States:
  - IDLE:
    - First cycle after reset release with AUTO_START=1 → PWRUP.
    - START=1 → PWRUP only if no run has completed since reset; otherwise → LOAD (power-up delay is not repeated).
    - Entering a run sets BUSY=1, clears END, ERROR and ERR_IDX, and sets idx=0 and retry=0.
  - PWRUP: count POWERUP_DLY cycles → LOAD.
  - LOAD: one cycle. XFER_DATA<=TBL_DATA → WAIT, with XFER_REQ=1 from the first WAIT cycle.
  - WAIT:
    - XFER_REQ held; timeout counter runs.
    - XFER_DONE & !XFER_NACK (success): XFER_REQ<=0 and retry<=0. If idx==NUM_REGS-1 → DONE; else idx<=idx+1 → GAP.
    - XFER_DONE & XFER_NACK, or timeout counter reaching TIMEOUT (failure): XFER_REQ<=0. If retry<MAX_RETRY: retry<=retry+1 → GAP with idx unchanged. Else ERR_IDX<=idx → FAIL.
    - XFER_DONE and timeout expiry in the same cycle: XFER_DONE wins.
  - GAP: count INTER_DLY cycles → LOAD. The retry path therefore reloads the same word.
  - DONE: END=1, BUSY=0 → IDLE.
  - FAIL: ERROR=1, BUSY=0 → IDLE.
- Handshake rules:
  - XFER_DONE outside WAIT is ignored.
  - START while BUSY is ignored; the running sequence is unaffected.
- Table timing: TBL_IDX updates on the cycle idx changes. TBL_DATA is sampled only in LOAD, ≥1 cycle later.
- Counter widths are sized from each parameter; no wrap is possible within a state.
- Latency, no retries, first run: POWERUP_DLY + NUM_REGS×(1 LOAD + WAIT time) + (NUM_REGS−1)×INTER_DLY + 1 cycles from IDLE exit to END.

Decomposition:
- Package codec_cfg_pkg holds:
  - state enum: IDLE, PWRUP, LOAD, WAIT, GAP, DONE, FAIL;
  - WM8731 register address constants (00h–09h, 0Fh reset);
  - reg_word(addr7, data9) function;
  - WM8731_DEV_ADDR = 7'h1A;
  - default 11-entry table constant, in order: reset 1E00h, 0017h, 0217h, 0497h, 0697h, 0800h, 0A00h, 0C00h, 0E51h, 1000h, 1201h.
- One sub-module, codec_cfg_rom (combinational, indexed by TBL_IDX, contents from the package), instantiated beside the sequencer in the parent. The sequencer itself stays table-agnostic.

Test Plan:
1. NUM_REGS=3, POWERUP_DLY=8, INTER_DLY=2, master ACKs 3 cycles after REQ → XFER_DATA = table[0..2] in order, exactly 3 REQs, END=1 and BUSY=0 at the cycle count given by the latency formula, ERROR=0.
2. NACK on entry 1, first attempt only, MAX_RETRY=3 → entry 1 sent twice with a 2-cycle gap between attempts, sequence completes, END=1.
3. Entry 2 NACKs every attempt, MAX_RETRY=2 → 3 attempts on idx 2, ERROR=1, ERR_IDX=2, END=0, no further REQ.
4. TIMEOUT=16, master never responds → XFER_REQ drops after 16 WAIT cycles, retries follow, ERROR=1 with ERR_IDX=0. XFER_DONE coincident with expiry → counted as success.
5. RESET asserted mid-WAIT on idx 1 → XFER_REQ=0 in the same cycle (asynchronous), all outputs 0. After release, AUTO_START=1 restarts from idx 0 with the full POWERUP_DLY.
6. After END, pulse START → END clears, no power-up wait, LOAD of idx 0 next cycle. START pulsed while BUSY → no effect on idx or REQ sequence.

Source files
------------

// File: rtl/codec_cfg_pkg.sv
// Shared types and WM8731 power-up configuration data for the codec init sequencer.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PWRUP = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5,
        FAIL  = 3'd6
    } seq_state_e;

    localparam logic [6:0] WM8731_DEV_ADDR = 7'h1A;

    localparam logic [6:0] WM_R_LLIN   = 7'h00;
    localparam logic [6:0] WM_R_RLIN   = 7'h01;
    localparam logic [6:0] WM_R_LHP    = 7'h02;
    localparam logic [6:0] WM_R_RHP    = 7'h03;
    localparam logic [6:0] WM_R_APATH  = 7'h04;
    localparam logic [6:0] WM_R_DPATH  = 7'h05;
    localparam logic [6:0] WM_R_PWR    = 7'h06;
    localparam logic [6:0] WM_R_IFACE  = 7'h07;
    localparam logic [6:0] WM_R_SRATE  = 7'h08;
    localparam logic [6:0] WM_R_ACTIVE = 7'h09;
    localparam logic [6:0] WM_R_RESET  = 7'h0F;

    function automatic logic [15:0] reg_word(input logic [6:0] addr7, input logic [8:0] data9);
        return {addr7, data9};
    endfunction

    localparam int WM8731_NUM_DEFAULT = 11;

    // Reset first, then line-in/headphone levels, paths, power, I2S format, rate, activate.
    localparam logic [15:0] WM8731_INIT_TABLE [WM8731_NUM_DEFAULT] = '{
        reg_word(WM_R_RESET,  9'h000),
        reg_word(WM_R_LLIN,   9'h017),
        reg_word(WM_R_RLIN,   9'h017),
        reg_word(WM_R_LHP,    9'h097),
        reg_word(WM_R_RHP,    9'h097),
        reg_word(WM_R_APATH,  9'h000),
        reg_word(WM_R_DPATH,  9'h000),
        reg_word(WM_R_PWR,    9'h000),
        reg_word(WM_R_IFACE,  9'h051),
        reg_word(WM_R_SRATE,  9'h000),
        reg_word(WM_R_ACTIVE, 9'h001)
    };

endpackage

// File: rtl/codec_cfg_rom.sv
// Combinational lookup of the default WM8731 init table; entries past the table read as zero.
module codec_cfg_rom
    import codec_cfg_pkg::*;
#(
    parameter int NUM_REGS = WM8731_NUM_DEFAULT,
    parameter int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [15:0]      data_o
);

    localparam int SEL_W = $clog2(WM8731_NUM_DEFAULT);

    logic [SEL_W-1:0] sel_s;

    // Table read with range guard.
    always_comb begin
        sel_s  = SEL_W'(idx_i);
        data_o = 16'h0000;
        if ((int'(idx_i) < NUM_REGS) && (int'(idx_i) < WM8731_NUM_DEFAULT)) begin
            data_o = WM8731_INIT_TABLE[sel_s];
        end else begin
            data_o = 16'h0000;
        end
    end

endmodule

// File: rtl/codec_init_sequencer.sv
// Power-up register-write sequencer: walks an external table and drives an I2C
// byte-write master with power-up delay, inter-write gap, NACK/timeout retry and error report.
module codec_init_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int         NUM_REGS    = 11,
    parameter int         WORD_W      = 16,
    parameter logic [6:0] DEV_ADDR    = WM8731_DEV_ADDR,
    parameter int         POWERUP_DLY = 256,
    parameter int         INTER_DLY   = 64,
    parameter int         MAX_RETRY   = 3,
    parameter int         TIMEOUT     = 4096,
    parameter bit         AUTO_START  = 1'b1,
    parameter int         IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic              START,
    output logic [IDX_W-1:0]  TBL_IDX,
    input  logic [WORD_W-1:0] TBL_DATA,
    output logic              XFER_REQ,
    output logic [6:0]        XFER_DEV,
    output logic [WORD_W-1:0] XFER_DATA,
    input  logic              XFER_DONE,
    input  logic              XFER_NACK,
    output logic              BUSY,
    output logic              END,
    output logic              ERROR,
    output logic [IDX_W-1:0]  ERR_IDX
);

    // One counter serves PWRUP, GAP and WAIT; it only ever counts to (limit - 1).
    localparam int DLY_MAX_A = (POWERUP_DLY > INTER_DLY) ? POWERUP_DLY : INTER_DLY;
    localparam int DLY_MAX   = (DLY_MAX_A > TIMEOUT) ? DLY_MAX_A : TIMEOUT;
    localparam int CNT_W     = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam int RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]   PWR_LAST  = CNT_W'(POWERUP_DLY - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(INTER_DLY - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_REGS - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    localparam seq_state_e FIRST_STATE = (POWERUP_DLY > 0) ? PWRUP : LOAD;
    localparam seq_state_e NEXT_ATTEMPT = (INTER_DLY > 0) ? GAP : LOAD;

    seq_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic               busy_q, busy_d;
    logic               end_q, end_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic               ran_q, ran_d;
    logic               auto_q, auto_d;
    logic               tmo_hit_s;

    // Next-state and output-register logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        data_d    = data_q;
        busy_d    = busy_q;
        end_d     = end_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        ran_d     = ran_q;
        auto_d    = auto_q;
        tmo_hit_s = 1'b0;

        case (state_q)
            IDLE: begin
                // Auto start fires only on the very first idle cycle after reset.
                auto_d = 1'b1;
                if ((AUTO_START && !auto_q) || START) begin
                    busy_d    = 1'b1;
                    end_d     = 1'b0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    idx_d     = '0;
                    retry_d   = '0;
                    cnt_d     = '0;
                    state_d   = ran_q ? LOAD : FIRST_STATE;
                end else begin
                    state_d = IDLE;
                end
            end

            PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            LOAD: begin
                data_d  = TBL_DATA;
                req_d   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT;
            end

            WAIT: begin
                tmo_hit_s = (TIMEOUT > 0) && (cnt_q == TMO_LAST);
                if (XFER_DONE && !XFER_NACK) begin
                    req_d   = 1'b0;
                    retry_d = '0;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = NEXT_ATTEMPT;
                    end
                end else if (XFER_DONE || tmo_hit_s) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = NEXT_ATTEMPT;
                    end else begin
                        err_idx_d = idx_q;
                        state_d   = FAIL;
                    end
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end

            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                end_d   = 1'b1;
                busy_d  = 1'b0;
                ran_d   = 1'b1;
                state_d = IDLE;
            end

            FAIL: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                ran_d   = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the request immediately.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            end_q     <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            ran_q     <= 1'b0;
            auto_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            end_q     <= end_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            ran_q     <= ran_d;
            auto_q    <= auto_d;
        end
    end

    assign TBL_IDX   = idx_q;
    assign XFER_REQ  = req_q;
    assign XFER_DEV  = DEV_ADDR;
    assign XFER_DATA = data_q;
    assign BUSY      = busy_q;
    assign END       = end_q;
    assign ERROR     = err_q;
    assign ERR_IDX   = err_idx_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Directed bench: sequencer plus default ROM, with a behavioural I2C master that can ACK, NACK or stay silent.
module tb_codec_init_sequencer;

    localparam int N  = 3;
    localparam int P  = 8;
    localparam int G  = 2;
    localparam int MR = 2;
    localparam int TO = 16;
    localparam int IW = 2;

    logic          MCLK = 1'b0;
    logic          RESET = 1'b1;
    logic          START = 1'b0;
    logic [IW-1:0] TBL_IDX;
    logic [15:0]   TBL_DATA;
    logic          XFER_REQ;
    logic [6:0]    XFER_DEV;
    logic [15:0]   XFER_DATA;
    logic          XFER_DONE = 1'b0;
    logic          XFER_NACK = 1'b0;
    logic          BUSY;
    logic          END;
    logic          ERROR;
    logic [IW-1:0] ERR_IDX;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat;
    int c0;

    // Master behaviour knobs: ack_cyc = REQ-high cycle in which DONE is pulsed (0 = never).
    int ack_cyc = 4;
    int nack_idx = -1;
    bit nack_all = 1'b0;
    int req_cycles = 0;
    bit req_prev = 1'b0;
    int attempts [4];
    logic [15:0] log_data [$];
    int rise_cyc [$];
    int fall_cyc [$];

    always #5 MCLK = ~MCLK;

    always @(posedge MCLK) cyc <= cyc + 1;

    codec_cfg_rom #(.NUM_REGS(N), .IDX_W(IW)) u_rom (
        .idx_i (TBL_IDX),
        .data_o(TBL_DATA)
    );

    codec_init_sequencer #(
        .NUM_REGS(N), .WORD_W(16), .DEV_ADDR(7'h1A), .POWERUP_DLY(P), .INTER_DLY(G),
        .MAX_RETRY(MR), .TIMEOUT(TO), .AUTO_START(1'b1), .IDX_W(IW)
    ) dut (
        .MCLK(MCLK), .RESET(RESET), .START(START), .TBL_IDX(TBL_IDX), .TBL_DATA(TBL_DATA),
        .XFER_REQ(XFER_REQ), .XFER_DEV(XFER_DEV), .XFER_DATA(XFER_DATA),
        .XFER_DONE(XFER_DONE), .XFER_NACK(XFER_NACK),
        .BUSY(BUSY), .END(END), .ERROR(ERROR), .ERR_IDX(ERR_IDX)
    );

    // Behavioural I2C master: logs each attempt and answers on the negative edge.
    always @(negedge MCLK) begin
        XFER_DONE = 1'b0;
        XFER_NACK = 1'b0;
        if (XFER_REQ) begin
            if (!req_prev) begin
                req_cycles = 0;
                attempts[TBL_IDX] = attempts[TBL_IDX] + 1;
                log_data.push_back(XFER_DATA);
                rise_cyc.push_back(cyc);
            end
            req_cycles = req_cycles + 1;
            if (ack_cyc != 0 && req_cycles == ack_cyc) begin
                XFER_DONE = 1'b1;
                XFER_NACK = (int'(TBL_IDX) == nack_idx) && (nack_all || attempts[TBL_IDX] == 1);
            end
        end else if (req_prev) begin
            fall_cyc.push_back(cyc);
        end
        req_prev = XFER_REQ;
    end

    task automatic tick();
        @(negedge MCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_data.delete();
        rise_cyc.delete();
        fall_cyc.delete();
        for (int i = 0; i < 4; i++) attempts[i] = 0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_finish(input int start_cyc, output int latency);
        for (int i = 0; i < 400 && !(END || ERROR); i++) tick();
        latency = cyc - start_cyc;
    endtask

    initial begin
        clear_log();
        RESET = 1'b1;
        repeat (3) tick();
        chk("rst_req", XFER_REQ, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_end", END, 0);
        chk("rst_error", ERROR, 0);
        chk("rst_err_idx", ERR_IDX, 0);
        chk("rst_tbl_idx", TBL_IDX, 0);
        chk("rst_data", XFER_DATA, 0);
        chk("dev_addr", XFER_DEV, 7'h1A);

        // Auto-started clean run: P + N*(1+4) + (N-1)*G + 1 = 28.
        RESET = 1'b0;
        for (int i = 0; i < 10 && !BUSY; i++) tick();
        chk("t1_busy_on", BUSY, 1);
        c0 = cyc;
        wait_finish(c0, lat);
        chk("t1_latency", lat, 28);
        chk("t1_end", END, 1);
        chk("t1_error", ERROR, 0);
        chk("t1_busy_off", BUSY, 0);
        chk("t1_nreq", log_data.size(), 3);
        chk("t1_d0", log_data[0], 16'h1E00);
        chk("t1_d1", log_data[1], 16'h0017);
        chk("t1_d2", log_data[2], 16'h0217);
        chk("t1_req_len", fall_cyc[0] - rise_cyc[0], 4);
        chk("t1_gap", rise_cyc[1] - fall_cyc[0], G + 1);

        // Rerun via START (no power-up), entry 1 NACKs once, stray START while busy.
        clear_log();
        nack_idx = 1;
        nack_all = 1'b0;
        pulse_start();
        c0 = cyc;
        chk("t2_end_clr", END, 0);
        chk("t2_busy", BUSY, 1);
        chk("t2_idx0", TBL_IDX, 0);
        chk("t2_req_load", XFER_REQ, 0);
        tick();
        chk("t2_req_wait", XFER_REQ, 1);
        chk("t2_data0", XFER_DATA, 16'h1E00);
        repeat (5) tick();
        pulse_start();
        wait_finish(c0, lat);
        chk("t2_latency", lat, 27);
        chk("t2_end", END, 1);
        chk("t2_nreq", log_data.size(), 4);
        chk("t2_att1", attempts[1], 2);
        chk("t2_d1", log_data[1], 16'h0017);
        chk("t2_d2", log_data[2], 16'h0017);
        chk("t2_d3", log_data[3], 16'h0217);
        chk("t2_retry_gap", rise_cyc[2] - fall_cyc[1], G + 1);

        // Entry 2 NACKs every attempt: 1 + MR attempts then ERROR.
        clear_log();
        nack_idx = 2;
        nack_all = 1'b1;
        pulse_start();
        c0 = cyc;
        chk("t3_end_clr", END, 0);
        wait_finish(c0, lat);
        chk("t3_latency", lat, 34);
        chk("t3_error", ERROR, 1);
        chk("t3_err_idx", ERR_IDX, 2);
        chk("t3_end", END, 0);
        chk("t3_busy", BUSY, 0);
        chk("t3_att2", attempts[2], 3);
        repeat (20) tick();
        chk("t3_no_more_req", log_data.size(), 5);

        // Silent master: every attempt times out after TO cycles.
        clear_log();
        nack_idx = -1;
        nack_all = 1'b0;
        ack_cyc = 0;
        pulse_start();
        c0 = cyc;
        chk("t4_err_clr", ERROR, 0);
        chk("t4_err_idx_clr", ERR_IDX, 0);
        wait_finish(c0, lat);
        chk("t4_latency", lat, 56);
        chk("t4_error", ERROR, 1);
        chk("t4_err_idx", ERR_IDX, 0);
        chk("t4_att0", attempts[0], 3);
        chk("t4_req_len", fall_cyc[0] - rise_cyc[0], TO);

        // DONE in the same cycle as timeout expiry counts as success.
        clear_log();
        ack_cyc = TO;
        pulse_start();
        c0 = cyc;
        wait_finish(c0, lat);
        chk("t4b_latency", lat, 56);
        chk("t4b_end", END, 1);
        chk("t4b_error", ERROR, 0);
        chk("t4b_nreq", log_data.size(), 3);
        chk("t4b_d2", log_data[2], 16'h0217);

        // Asynchronous reset in WAIT on entry 1, then full auto restart.
        clear_log();
        ack_cyc = 4;
        pulse_start();
        for (int i = 0; i < 60 && !(XFER_REQ && TBL_IDX == 2'd1); i++) tick();
        chk("t5_reached_idx1", XFER_REQ && (TBL_IDX == 2'd1), 1);
        RESET = 1'b1;
        #1;
        chk("t5_req_async", XFER_REQ, 0);
        chk("t5_busy", BUSY, 0);
        chk("t5_tbl_idx", TBL_IDX, 0);
        chk("t5_data", XFER_DATA, 0);
        chk("t5_end", END, 0);
        repeat (2) tick();
        clear_log();
        RESET = 1'b0;
        for (int i = 0; i < 10 && !BUSY; i++) tick();
        chk("t5_busy_on", BUSY, 1);
        c0 = cyc;
        wait_finish(c0, lat);
        chk("t5_latency", lat, 28);
        chk("t5_first_req", rise_cyc[0] - c0, P + 1);
        chk("t5_d0", log_data[0], 16'h1E00);
        chk("t5_end_final", END, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
